// File: rtl/full_adder_unit_pkg.sv
// Shared constants and result type for the full_adder_unit family.
// Imported by the interface, the top level and any wrappers.
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

  typedef struct packed {
    logic                    carry;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_sum_t;

endpackage

// File: rtl/full_adder_unit_if.sv
// Operand/result bundle for full_adder_unit.
// Signal V exists only when FULL_ADDER_UNIT_OVERFLOW_EN is defined.
interface full_adder_unit_if #(
  parameter int WIDTH = full_adder_pkg::FA_DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             out_valid;
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
  logic             V;

  modport master (output in_valid, A, B, Cin, input S, Cout, out_valid, V);
  modport slave  (input in_valid, A, B, Cin, output S, Cout, out_valid, V);
`else
  modport master (output in_valid, A, B, Cin, input S, Cout, out_valid);
  modport slave  (input in_valid, A, B, Cin, output S, Cout, out_valid);
`endif

endinterface

// File: rtl/full_adder_unit_fa_bit.sv
// Combinational one-bit full adder: the leaf cell of the ripple chain.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder {Cout,S} = A + B + Cin with one cycle latency.
// Optional signed-overflow output V under FULL_ADDER_UNIT_OVERFLOW_EN.
module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  full_adder_unit_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  assign carry[0] = bus.Cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
      fa_bit u_bit (
        .a  (bus.A[gi]),
        .b  (bus.B[gi]),
        .ci (carry[gi]),
        .s  (sum_c[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  // Result registers only move on a valid input, so junk operands while idle are ignored.
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      s_d    = sum_c;
      cout_d = carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.out_valid = valid_q;

`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
  logic v_q, v_d;

  // Two's-complement overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    v_d = v_q;
    if (bus.in_valid) begin
      v_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end

  assign bus.V = v_q;
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit at WIDTH = 1, 8 and 64 driven in parallel.
// Define FULL_ADDER_UNIT_OVERFLOW_EN to also check V.
module tb_full_adder_unit;

  logic        clk = 1'b0;
  logic        rst_r = 1'b1;
  logic        vld_r = 1'b0;
  logic [63:0] a_r = '0;
  logic [63:0] b_r = '0;
  logic        cin_r = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  full_adder_unit_if #(.WIDTH(1))  if1  ();
  full_adder_unit_if #(.WIDTH(8))  if8  ();
  full_adder_unit_if #(.WIDTH(64)) if64 ();

  assign if1.in_valid  = vld_r;
  assign if1.A         = a_r[0];
  assign if1.B         = b_r[0];
  assign if1.Cin       = cin_r;
  assign if8.in_valid  = vld_r;
  assign if8.A         = a_r[7:0];
  assign if8.B         = b_r[7:0];
  assign if8.Cin       = cin_r;
  assign if64.in_valid = vld_r;
  assign if64.A        = a_r;
  assign if64.B        = b_r;
  assign if64.Cin      = cin_r;

  full_adder_unit #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst_r), .bus(if1));
  full_adder_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst_r), .bus(if8));
  full_adder_unit #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst_r), .bus(if64));

  // DUT outputs gathered per instance: index 0 -> WIDTH 1, 1 -> WIDTH 8, 2 -> WIDTH 64.
  logic [63:0] act_s  [3];
  logic        act_c  [3];
  logic        act_ov [3];
  logic        act_v  [3];

  assign act_s[0]  = {63'd0, if1.S};
  assign act_s[1]  = {56'd0, if8.S};
  assign act_s[2]  = if64.S;
  assign act_c[0]  = if1.Cout;
  assign act_c[1]  = if8.Cout;
  assign act_c[2]  = if64.Cout;
  assign act_ov[0] = if1.out_valid;
  assign act_ov[1] = if8.out_valid;
  assign act_ov[2] = if64.out_valid;
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
  assign act_v[0]  = if1.V;
  assign act_v[1]  = if8.V;
  assign act_v[2]  = if64.V;
`else
  assign act_v[0]  = 1'b0;
  assign act_v[1]  = 1'b0;
  assign act_v[2]  = 1'b0;
`endif

  function automatic int width_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 8 : 64;
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Unsigned reference: A + B + Cin in 65-bit arithmetic; bit w is the carry-out.
  function automatic logic [64:0] ref_add(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic c);
    logic [63:0] m;
    m = mask_of(w);
    return {1'b0, a & m} + {1'b0, b & m} + {64'd0, c};
  endfunction

  // Signed reference: does A + B + Cin leave the w-bit two's-complement range?
  function automatic logic ref_ovf(input int w, input logic [63:0] a,
                                   input logic [63:0] b, input logic c);
    logic signed [66:0] one, sa, sb, r, hi, lo;
    logic [63:0] m;
    m   = mask_of(w);
    one = 67'sd1;
    sa  = $signed({3'b000, a & m});
    sb  = $signed({3'b000, b & m});
    if (a[w-1]) sa = sa - (one <<< w);
    if (b[w-1]) sb = sb - (one <<< w);
    r  = sa + sb + (c ? one : 67'sd0);
    hi = (one <<< (w - 1)) - one;
    lo = -(one <<< (w - 1));
    return (r > hi) || (r < lo);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: last accepted result per width, cleared by reset.
  logic [63:0] exp_s  [3];
  logic        exp_c  [3];
  logic        exp_ov [3];
  logic        exp_v  [3];
  logic        model_ok = 1'b0;

  always @(posedge clk) begin : model
    logic [64:0] r;
    for (int k = 0; k < 3; k++) begin
      if (rst_r) begin
        exp_s[k]  <= '0;
        exp_c[k]  <= 1'b0;
        exp_v[k]  <= 1'b0;
        exp_ov[k] <= 1'b0;
      end else begin
        if (vld_r) begin
          r = ref_add(width_of(k), a_r, b_r, cin_r);
          exp_s[k] <= r[63:0] & mask_of(width_of(k));
          exp_c[k] <= r[width_of(k)];
          exp_v[k] <= ref_ovf(width_of(k), a_r, b_r, cin_r);
        end
        exp_ov[k] <= vld_r;
      end
    end
    if (rst_r) model_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_S_w%0d", width_of(k)), act_s[k], exp_s[k]);
        chk($sformatf("model_Cout_w%0d", width_of(k)), {63'd0, act_c[k]}, {63'd0, exp_c[k]});
        chk($sformatf("model_valid_w%0d", width_of(k)), {63'd0, act_ov[k]}, {63'd0, exp_ov[k]});
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
        chk($sformatf("model_V_w%0d", width_of(k)), {63'd0, act_v[k]}, {63'd0, exp_v[k]});
`endif
      end
    end
  end

  task automatic step(input logic rst, input logic vld, input logic [63:0] a,
                      input logic [63:0] b, input logic c, input bit verbose);
    rst_r = rst;
    vld_r = vld;
    a_r   = a;
    b_r   = b;
    cin_r = c;
    @(posedge clk);
    #2;
    if (verbose)
      $display("txn rst=%0d vld=%0d A=%h B=%h Cin=%0d -> w1 %0d%0d w8 %0d_%h w64 %0d_%h",
               rst, vld, a, b, c, if1.Cout, if1.S, if8.Cout, if8.S, if64.Cout, if64.S);
  endtask

  logic [1:0] sweep_exp [8];

  initial begin
    sweep_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    chk("reset_S_w8", {56'd0, if8.S}, 64'd0);
    chk("reset_valid_w64", {63'd0, if64.out_valid}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v3;
      v3 = i[2:0];
      step(1'b0, 1'b1, {63'd0, v3[2]}, {63'd0, v3[1]}, v3[0], 1'b1);
      chk($sformatf("sweep_%0d", i), {62'd0, if1.Cout, if1.S}, {62'd0, sweep_exp[i]});
      chk($sformatf("sweep_valid_%0d", i), {63'd0, if1.out_valid}, 64'd1);
    end

    step(1'b1, 1'b1, 64'd1, 64'd1, 1'b1, 1'b1);
    chk("rst_prio_S", {63'd0, if1.S}, 64'd0);
    chk("rst_prio_Cout", {63'd0, if1.Cout}, 64'd0);
    chk("rst_prio_valid", {63'd0, if1.out_valid}, 64'd0);
    step(1'b0, 1'b1, 64'd1, 64'd1, 1'b1, 1'b1);
    chk("post_rst_SC", {62'd0, if1.Cout, if1.S}, 64'd3);

    step(1'b0, 1'b1, 64'd1, 64'd0, 1'b0, 1'b1);
    chk("hold_load", {62'd0, if1.Cout, if1.S}, 64'd1);
    step(1'b0, 1'b0, 64'd1, 64'd1, 1'b0, 1'b1);
    chk("hold_SC", {62'd0, if1.Cout, if1.S}, 64'd1);
    chk("hold_valid", {63'd0, if1.out_valid}, 64'd0);

    step(1'b0, 1'b1, 64'hFF, 64'h01, 1'b0, 1'b1);
    chk("w8_ff_01", {55'd0, if8.Cout, if8.S}, 64'h100);
    chk("w8_ff_01_valid", {63'd0, if8.out_valid}, 64'd1);
    step(1'b0, 1'b1, 64'h12, 64'h34, 1'b1, 1'b1);
    chk("w8_12_34_b2b", {55'd0, if8.Cout, if8.S}, 64'h047);
    chk("w8_12_34_valid", {63'd0, if8.out_valid}, 64'd1);

    step(1'b0, 1'b1, 64'h7F, 64'h01, 1'b0, 1'b1);
    chk("w8_7f_01", {55'd0, if8.Cout, if8.S}, 64'h080);
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
    chk("w8_7f_01_V", {63'd0, if8.V}, 64'd1);
`endif
    step(1'b0, 1'b1, 64'hFF, 64'h01, 1'b0, 1'b1);
`ifdef FULL_ADDER_UNIT_OVERFLOW_EN
    chk("w8_ff_01_V", {63'd0, if8.V}, 64'd0);
`endif
    chk("w64_S", if64.S, 64'h0000_0000_0000_0100);

    step(1'b0, 1'b1, {64{1'b1}}, 64'd1, 1'b0, 1'b1);
    chk("w64_wrap_S", if64.S, 64'd0);
    chk("w64_wrap_Cout", {63'd0, if64.Cout}, 64'd1);

    for (int n = 0; n < 10000; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 1), 1'b1);
    end

    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
